// File: rtl/bp_stall_prof_pkg.sv
// Shared types and constants for the stall-counter control sequencer.
package bp_stall_prof_pkg;

    typedef enum logic [1:0] {
        e_cmd_start = 2'd0,
        e_cmd_stop  = 2'd1,
        e_cmd_clear = 2'd2,
        e_cmd_snap  = 2'd3
    } bp_stall_cmd_e;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_snap  = 2'd1,
        e_drain = 2'd2,
        e_clear = 2'd3
    } bp_stall_ctrl_state_e;

    localparam int unsigned overrun_width_gp = 8;

endpackage

// File: rtl/bp_stall_period_timer.sv
// Free-running period timer; pulses tick_o once every period_i enabled cycles.
module bp_stall_period_timer #(
    parameter int unsigned width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [width_p-1:0] period_i,
    output logic               tick_o
);

    localparam logic [width_p-1:0] one = width_p'(1);

    logic [width_p-1:0] count_r;

    // >= rather than == so a shrinking period fires at once instead of wrapping
    assign tick_o = en_i && (period_i != '0) && (count_r >= period_i - one);

    // Count enabled cycles, restarting on tick or explicit clear
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (clr_i || tick_o) begin
            count_r <= '0;
        end else if (en_i) begin
            count_r <= count_r + one;
        end
    end

endmodule

// File: rtl/bp_stall_counter_ctrl.sv
// Freeze/clear control and atomic snapshot readout for the stall-counter bank.
module bp_stall_counter_ctrl
    import bp_stall_prof_pkg::*;
#(
    parameter int unsigned num_counters_p = 18,
    parameter int unsigned width_p        = 32,
    localparam int unsigned idx_width_lp  = $clog2(num_counters_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              cmd_v_i,
    input  logic [1:0]                        cmd_i,
    output logic                              cmd_ready_o,
    input  logic [width_p-1:0]                period_i,
    input  logic [num_counters_p*width_p-1:0] counters_i,
    output logic                              freeze_o,
    output logic                              clear_o,
    output logic [width_p-1:0]                data_o,
    output logic [idx_width_lp-1:0]           data_idx_o,
    output logic                              data_v_o,
    output logic                              data_last_o,
    input  logic                              data_ready_i,
    output logic [overrun_width_gp-1:0]       overrun_o,
    output logic                              busy_o
);

    localparam logic [overrun_width_gp-1:0] overrun_max = '1;
    localparam logic [idx_width_lp-1:0]     last_idx    = idx_width_lp'(num_counters_p);

    bp_stall_ctrl_state_e state_r, state_next;
    bp_stall_cmd_e        cmd;

    logic                          run_r;
    logic [width_p-1:0]            seq_r;
    logic [idx_width_lp-1:0]       idx_r;
    logic [overrun_width_gp-1:0]   overrun_r;
    logic [width_p-1:0]            shadow_r [num_counters_p];

    logic cmd_fire, tick, timer_en, timer_clr, tick_drop, last_beat;

    assign cmd        = bp_stall_cmd_e'(cmd_i);
    assign cmd_fire   = cmd_v_i && (state_r == e_idle);
    assign timer_en   = run_r && (period_i != '0);
    assign timer_clr  = (cmd_fire && (cmd == e_cmd_start)) || (state_r == e_clear);
    // A tick is only usable in IDLE when no command claims the cycle
    assign tick_drop  = tick && ((state_r != e_idle) || cmd_fire);
    assign last_beat  = (idx_r == last_idx);

    bp_stall_period_timer #(
        .width_p (width_p)
    ) u_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (timer_en),
        .clr_i     (timer_clr),
        .period_i  (period_i),
        .tick_o    (tick)
    );

    // Next-state: commands outrank a coincident tick
    always_comb begin
        state_next = state_r;
        case (state_r)
            e_idle: begin
                if (cmd_fire) begin
                    if (cmd == e_cmd_clear) begin
                        state_next = e_clear;
                    end else if (cmd == e_cmd_snap) begin
                        state_next = e_snap;
                    end
                end else if (tick) begin
                    state_next = e_snap;
                end
            end
            e_snap:  state_next = e_drain;
            e_drain: if (data_ready_i && last_beat) state_next = e_idle;
            e_clear: state_next = e_idle;
            default: state_next = e_idle;
        endcase
    end

    // Control state, sequence number, beat index and overrun counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_idle;
            run_r     <= 1'b0;
            seq_r     <= '0;
            idx_r     <= '0;
            overrun_r <= '0;
        end else begin
            state_r <= state_next;
            if (cmd_fire && (cmd == e_cmd_start)) run_r <= 1'b1;
            if (cmd_fire && (cmd == e_cmd_stop))  run_r <= 1'b0;
            if (state_r == e_snap) begin
                seq_r <= seq_r + width_p'(1);
                idx_r <= '0;
            end else if (state_r == e_clear) begin
                seq_r <= '0;
            end
            if (state_r == e_drain && data_ready_i) begin
                idx_r <= last_beat ? '0 : idx_r + idx_width_lp'(1);
            end
            if (state_r == e_clear) begin
                overrun_r <= '0;
            end else if (tick_drop && (overrun_r != overrun_max)) begin
                overrun_r <= overrun_r + 1'b1;
            end
        end
    end

    // Shadow copy: every counter captured on the same edge
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shadow_r <= '{default: '0};
        end else if (state_r == e_snap) begin
            for (int k = 0; k < num_counters_p; k++) begin
                shadow_r[k] <= counters_i[k*width_p +: width_p];
            end
        end
    end

    // Readout mux: beat 0 is the sequence number, beat k+1 is counter k
    always_comb begin
        data_o = seq_r;
        for (int k = 0; k < num_counters_p; k++) begin
            if (idx_r == idx_width_lp'(k + 1)) data_o = shadow_r[k];
        end
    end

    assign data_idx_o  = idx_r;
    assign data_v_o    = (state_r == e_drain);
    assign data_last_o = (state_r == e_drain) && last_beat;
    assign clear_o     = (state_r == e_clear);
    assign cmd_ready_o = (state_r == e_idle);
    assign busy_o      = (state_r != e_idle);
    assign freeze_o    = ~run_r;
    assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_bp_stall_counter_ctrl.sv
// Scoreboard bench for bp_stall_counter_ctrl: expected beats are queued by the
// stimulus thread and consumed by a monitor on every data handshake.
module tb_bp_stall_counter_ctrl;

    localparam int N = 18;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        logic [4:0]   idx;
        logic         last;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset_n_i = 1'b1;
    logic           cmd_v_i = 1'b0;
    logic [1:0]     cmd_i = 2'd0;
    logic           cmd_ready_o;
    logic [W-1:0]   period_i = '0;
    logic [N*W-1:0] counters_i = '0;
    logic           freeze_o, clear_o, data_v_o, data_last_o, busy_o;
    logic [W-1:0]   data_o;
    logic [4:0]     data_idx_o;
    logic           data_ready_i = 1'b1;
    logic [7:0]     overrun_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [W-1:0] cur_vals [N];
    beat_t exp_q [$];
    int sample_cyc [$];
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic [4:0] prev_idx;

    bp_stall_counter_ctrl #(
        .num_counters_p (N),
        .width_p        (W)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .cmd_v_i      (cmd_v_i),
        .cmd_i        (cmd_i),
        .cmd_ready_o  (cmd_ready_o),
        .period_i     (period_i),
        .counters_i   (counters_i),
        .freeze_o     (freeze_o),
        .clear_o      (clear_o),
        .data_o       (data_o),
        .data_idx_o   (data_idx_o),
        .data_v_o     (data_v_o),
        .data_last_o  (data_last_o),
        .data_ready_i (data_ready_i),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: stability while stalled, then pop-and-compare on each handshake
    always @(negedge clk) begin
        if (reset_n_i && data_v_o) begin
            if (prev_stall) begin
                check("hold_data", data_o, prev_data);
                check("hold_idx", data_idx_o, prev_idx);
            end
            if (data_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", data_o, e.data);
                    check("beat_idx", data_idx_o, e.idx);
                    check("beat_last", data_last_o, e.last);
                end
                if (data_idx_o == 5'd0) sample_cyc.push_back(cyc);
            end
            prev_stall = !data_ready_i;
            prev_data  = data_o;
            prev_idx   = data_idx_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic set_counters(input bit linear);
        for (int k = 0; k < N; k++) begin
            cur_vals[k] = linear ? W'(k * 10 + 1) : (32'hdead0000 + W'(k));
            counters_i[k*W +: W] = cur_vals[k];
        end
    endtask

    task automatic push_sample(input logic [W-1:0] seq);
        beat_t b;
        b.data = seq; b.idx = 5'd0; b.last = 1'b0;
        exp_q.push_back(b);
        for (int k = 0; k < N; k++) begin
            b.data = cur_vals[k]; b.idx = 5'(k + 1); b.last = (k == N - 1);
            exp_q.push_back(b);
        end
    endtask

    // Offer a command and hold it until accepted; returns in the following cycle
    task automatic do_cmd(input logic [1:0] c);
        int n;
        cmd_v_i = 1'b1;
        cmd_i   = c;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                acc_cyc = cyc;
                break;
            end
            n++;
            if (n > 5000) begin
                check("cmd_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        cmd_v_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (!busy_o) break;
            n++;
            if (n > 5000) begin
                check(name, 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic tick_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] bp_pat;
        int n;
        bp_pat = 4'b1001;

        // Reset values
        #1 reset_n_i = 1'b0;
        #2;
        check("rst_freeze", freeze_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_data_v", data_v_o, 0);
        check("rst_clear", clear_o, 0);
        check("rst_last", data_last_o, 0);
        check("rst_overrun", overrun_o, 0);
        tick_cycles(2);
        reset_n_i = 1'b1;
        tick_cycles(1);

        // Start unfreezes the next cycle
        do_cmd(2'd0);
        @(negedge clk);
        check("start_freeze", freeze_o, 0);
        @(posedge clk); #1;

        // Manual snap with latency checks
        set_counters(1'b1);
        push_sample(32'd1);
        do_cmd(2'd3);
        @(negedge clk);
        check("snap_busy_t1", busy_o, 1);
        check("snap_v_t1", data_v_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("snap_v_t2", data_v_o, 1);
        @(posedge clk); #1;
        wait_idle("snap_idle_timeout");
        check("snap_idle_cycle", cyc - 1 - acc_cyc, 21);

        // Backpressure; live counters change after capture
        push_sample(32'd2);
        do_cmd(2'd3);
        n = 0;
        while (1) begin
            data_ready_i = bp_pat[n % 4];
            if (n == 1) set_counters(1'b0);
            @(negedge clk);
            if (!busy_o) break;
            n++;
            if (n > 500) begin
                check("bp_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        data_ready_i = 1'b1;

        // Clear pulse, freeze untouched
        do_cmd(2'd2);
        @(negedge clk);
        check("clr_pulse", clear_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("clr_pulse_end", clear_o, 0);
        check("clr_idle", busy_o, 0);
        check("clr_freeze", freeze_o, 0);
        @(posedge clk); #1;

        // Auto-sample every 100 cycles
        sample_cyc.delete();
        push_sample(32'd1);
        push_sample(32'd2);
        push_sample(32'd3);
        period_i = 32'd100;
        n = 0;
        while (sample_cyc.size() < 3 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        period_i = '0;
        check("auto_count", sample_cyc.size(), 3);
        if (sample_cyc.size() >= 3) begin
            check("auto_interval1", sample_cyc[1] - sample_cyc[0], 100);
            check("auto_interval2", sample_cyc[2] - sample_cyc[1], 100);
        end
        wait_idle("auto_idle_timeout");
        check("auto_overrun", overrun_o, 0);

        // Clear after seq 3, next snap reports seq 1
        do_cmd(2'd2);
        @(negedge clk);
        check("clr2_pulse", clear_o, 1);
        check("clr2_freeze", freeze_o, 0);
        @(posedge clk); #1;
        push_sample(32'd1);
        do_cmd(2'd3);
        wait_idle("snap2_idle_timeout");
        check("snap2_overrun", overrun_o, 0);

        // Overrun: one sample stuck in drain while ticks keep coming
        do_cmd(2'd1);
        @(negedge clk);
        check("stop_freeze", freeze_o, 1);
        @(posedge clk); #1;
        period_i = 32'd5;
        data_ready_i = 1'b0;
        push_sample(32'd2);
        do_cmd(2'd0);
        tick_cycles(60);
        @(negedge clk);
        check("ovr_11", overrun_o, 11);
        check("ovr_stuck_v", data_v_o, 1);
        check("ovr_stuck_idx", data_idx_o, 0);
        @(posedge clk); #1;
        tick_cycles(2000);
        @(negedge clk);
        check("ovr_sat", overrun_o, 255);
        @(posedge clk); #1;
        data_ready_i = 1'b1;
        do_cmd(2'd1);
        period_i = '0;
        @(negedge clk);
        check("ovr_stop_freeze", freeze_o, 1);
        check("ovr_hold_sat", overrun_o, 255);
        @(posedge clk); #1;
        do_cmd(2'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("ovr_cleared", overrun_o, 0);
        @(posedge clk); #1;

        // Async reset at beat 4
        push_sample(32'd1);
        do_cmd(2'd3);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (data_v_o && data_idx_o == 5'd4) break;
            n++;
            if (n > 100) begin
                check("rst_mid_timeout", 0, 1);
                break;
            end
        end
        #2 reset_n_i = 1'b0;
        #1;
        check("arst_data_v", data_v_o, 0);
        check("arst_freeze", freeze_o, 1);
        check("arst_busy", busy_o, 0);
        exp_q.delete();
        tick_cycles(2);
        reset_n_i = 1'b1;
        @(negedge clk);
        check("arst_idle", busy_o, 0);
        check("arst_ready", cmd_ready_o, 1);
        @(posedge clk); #1;
        push_sample(32'd1);
        do_cmd(2'd3);
        wait_idle("arst_snap_timeout");
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_stall_counter_ctrl.md
# bp_stall_counter_ctrl

Control and readout sequencer for the BlackParrot stall-counter bank in the black-parrot-example cosim. It drives the bank's freeze and clear controls and snapshots all counters atomically, either on command or on a periodic timer. Each snapshot is streamed out over a valid/ready port as one sequence-number beat followed by N counter beats, so host software reads a coherent sample instead of racing free-running counters.

## Interface
- num_counters_p, 18: number of counters in the bank (N); must be ≥1
- width_p, 32: counter, sequence and period width
- idx_width_lp, $clog2(num_counters_p+1): beat index width (localparam)
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- cmd_v_i  in  1  command valid
- cmd_i  in  2  command (start=0, stop=1, clear=2, snap=3)
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o
- period_i  in  width_p  auto-sample period in cycles; 0 disables auto-sample
- counters_i  in  N*width_p  live counter values; counter k at bits [k*width_p +: width_p]
- freeze_o  out  1  hold the counter bank (high = frozen)
- clear_o  out  1  one-cycle clear pulse to the counter bank
- data_o  out  width_p  readout beat
- data_idx_o  out  idx_width_lp  beat index (0 = sequence, k+1 = counter k)
- data_v_o  out  1  beat valid
- data_last_o  out  1  final beat of the sample
- data_ready_i  in  1  consumer ready
- overrun_o  out  8  saturating count of dropped auto-sample ticks
- busy_o  out  1  state ≠ IDLE

## Operation
- State machine (e_idle, e_snap, e_drain, e_clear). run_r is a separate flag; freeze_o = ~run_r.
- **IDLE**, cmd_ready_o = 1. Accepted commands:
  - start: run_r←1, timer←0
  - stop: run_r←0
  - clear: go to CLEAR
  - snap: go to SNAP
- **SNAP** (1 cycle):
  - shadow[k]←counters_i[k] for all k
  - seq_r←seq_r+1, wrapping at 2^width_p
  - idx←0, go to DRAIN
- **DRAIN**:
  - data_v_o = 1
  - data_o = seq_r when idx = 0, else shadow[idx-1]
  - data_last_o = (idx = N)
  - on data_v_o & data_ready_i: idx←idx+1; after the last beat, go to IDLE
- **CLEAR** (1 cycle):
  - clear_o = 1
  - seq_r←0, overrun←0, timer←0
  - run_r is unchanged; go to IDLE
- cmd_ready_o = 0 in SNAP, DRAIN and CLEAR; commands offered there are held by the requester, not dropped.
- **Timer**:
  - Counts only while run_r = 1 and period_i ≠ 0, in every state.
  - tick = timer ≥ period_i-1. The ≥ compare makes a mid-run period reduction fire immediately instead of wrapping.
  - On tick, timer←0.
- **Tick handling**:
  - Tick in IDLE with no command accepted that cycle: go to SNAP.
  - Tick in SNAP, DRAIN or CLEAR, or coincident with an accepted command: the tick is dropped and overrun increments, saturating at 255.
  - An accepted command always has priority over a coincident tick.
- **Snapshot source**: the shadow copy is taken from counters_i, so counts continue during DRAIN when run_r = 1.

## Timing
- **Reset values**:
  - state = IDLE, run_r = 0 (freeze_o = 1)
  - clear_o = 0, data_v_o = 0, data_last_o = 0
  - seq_r = 0, overrun_o = 0, timer = 0, idx = 0, shadow = 0
  - busy_o = 0, cmd_ready_o = 1
- Reset may assert mid-drain or mid-clear. All state clears asynchronously, and in-flight beats are abandoned with no further data_v_o.
- **Snap latency**: cmd accepted at cycle t → SNAP at t+1 (capture edge at end of t+1) → first beat valid at t+2.
- A full sample with data_ready_i held high takes N+1 beats, so IDLE is re-entered at t+N+3.
- **Clear latency**: cmd accepted at t → clear_o high during t+1 only → IDLE at t+2.
- start/stop: freeze_o changes the cycle after acceptance.
- data_o and data_idx_o are stable while data_v_o & ~data_ready_i. All outputs are registered or decoded from state only.

## Structure
- bp_stall_prof_pkg holds:
  - the bp_stall_cmd_e enum (2 bits)
  - the bp_stall_ctrl_state_e enum
  - the overrun width constant (8)
- Sub-module bp_stall_period_timer (width_p): inputs en_i, period_i, clr_i; output tick_o.
- Shadow storage is a flop array of N*width_p bits; it is not a RAM, because all entries are written in one cycle.

## Test plan
- **Manual snap**:
  - Stimulus: reset; start; counters_i = {k*10+1}; snap with data_ready_i = 1.
  - Response: beats seq=1, then 1, 11, …, 171 at idx 0..18; last only on idx 18; busy_o falls after the beat.
- **Backpressure**: data_ready_i toggles 1-0-0-1 during drain → each beat's data_o and data_idx_o are held while stalled, with no loss or duplication.
- **Auto-sample**:
  - Stimulus: period_i = 100, run, ready = 1.
  - Response: a sample every 100 cycles; seq 1,2,3; overrun_o = 0.
- **Overrun**:
  - Stimulus: period_i = 5, data_ready_i = 0 for 60 cycles.
  - Response: one sample stuck in drain; overrun_o = 11.
  - Continued: over 2000 stalled cycles overrun_o saturates at 255.
- **Clear**:
  - Stimulus: clear after seq = 3.
  - Response: clear_o pulses exactly 1 cycle; next snap reports seq = 1; overrun_o = 0; freeze_o unchanged.
- **Async reset mid-drain**: reset_n_i low at idx 4 → data_v_o = 0 and freeze_o = 1 without a clock edge; after release, state is IDLE and seq restarts at 1.
